// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned N_REQ_DEF      = 4;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned CNT_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_STALL = 2'd2
  } state_e;

  // Round-robin successor of ptr among n requesters.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer request bus plus FIFO write-side signals seen by the arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = N_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_data_in;
  logic                        fifo_full;
  logic                        fifo_almostfull;
  logic                        fifo_wr_ack;
  logic                        fifo_overflow;
  logic [CNT_WIDTH-1:0]        nack_cnt;
  logic                        ovf_err;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in, nack_cnt, ovf_err
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in, nack_cnt, ovf_err
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port among N_REQ producers with round-robin grants,
// full/almostfull throttling, a one-cycle write register and ack/overflow checking.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = N_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic             can_write;
  logic             any_req;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic             grant_any;
  logic [PW-1:0]    rr_ptr;
  logic             wr_d1;
  state_e           state_q;
  state_e           state_d;

  // The write already in flight will consume the last free slot.
  assign can_write = !bus.fifo_full && !(bus.fifo_almostfull && bus.fifo_wr_en);
  assign any_req   = |bus.req_valid;
  assign arb_req   = bus.req_valid & {N_REQ{can_write && rst_n}};
  assign bus.req_ready = grant;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Pointer, write register and ack checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= '0;
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_data_in <= '0;
      wr_d1            <= 1'b0;
      bus.nack_cnt     <= '0;
      bus.ovf_err      <= 1'b0;
    end else begin
      bus.fifo_wr_en <= grant_any;
      wr_d1          <= bus.fifo_wr_en;
      if (grant_any) begin
        rr_ptr           <= PW'(rr_next(32'(grant_idx), N_REQ));
        bus.fifo_data_in <= bus.req_data[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
      end
      if (wr_d1 && !bus.fifo_wr_ack && (bus.nack_cnt != {CNT_WIDTH{1'b1}}))
        bus.nack_cnt <= bus.nack_cnt + CNT_WIDTH'(1);
      if (wr_d1 && bus.fifo_overflow)
        bus.ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_any)                  state_d = S_WRITE;
        else if (any_req && !can_write) state_d = S_STALL;
      end
      S_WRITE: begin
        if (grant_any)    state_d = S_WRITE;
        else if (any_req) state_d = S_STALL;
        else              state_d = S_IDLE;
      end
      S_STALL: begin
        if (grant_any)     state_d = S_WRITE;
        else if (!any_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: depth-8 FIFO model, fault override, and an
// abstract arbitration/ack reference model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int DEPTH    = 8;
  localparam int NACK_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] words [N];
  assign bus.req_data = {words[3], words[2], words[1], words[0]};

  // Synchronous FIFO write side; drain pops every cycle, fifo_rd pops once.
  int   f_count;
  logic f_ack, f_ovf;
  logic fifo_rd, drain;
  logic force_en, force_ack, force_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_count <= 0;
      f_ack   <= 1'b0;
      f_ovf   <= 1'b0;
    end else begin
      f_ack   <= bus.fifo_wr_en && (f_count < DEPTH);
      f_ovf   <= bus.fifo_wr_en && (f_count >= DEPTH);
      f_count <= f_count + ((bus.fifo_wr_en && f_count < DEPTH) ? 1 : 0)
                         - (((fifo_rd || drain) && f_count > 0) ? 1 : 0);
    end
  end

  assign bus.fifo_full       = (f_count == DEPTH);
  assign bus.fifo_almostfull = (f_count == DEPTH - 1);
  assign bus.fifo_wr_ack     = force_en ? force_ack : f_ack;
  assign bus.fifo_overflow   = force_en ? force_ovf : f_ovf;

  // Reference model state
  int            m_ptr;
  logic          m_wr, m_wr_d1, m_ovf;
  logic [DW-1:0] m_data;
  int            m_nack;
  logic [N-1:0]  exp_ready, act_ready;
  int            g_idx;

  int checks = 0;
  int failures = 0;

  task automatic model_reset();
    m_ptr = 0; m_wr = 1'b0; m_wr_d1 = 1'b0; m_ovf = 1'b0; m_nack = 0; m_data = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    fifo_rd = 1'b0; drain = 1'b0;
    force_en = 1'b0; force_ack = 1'b0; force_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // One clock: predict the grant from the rules, capture, advance the model.
  task automatic tick();
    logic cw, ack_s, ovf_s;
    logic [DW-1:0] g_word;
    int idx;
    #1;
    cw = !bus.fifo_full && !(bus.fifo_almostfull && m_wr);
    g_idx = -1;
    if (cw) begin
      for (int k = 0; k < int'(N); k++) begin
        idx = (m_ptr + k) % int'(N);
        if (g_idx < 0 && bus.req_valid[idx]) g_idx = idx;
      end
    end
    exp_ready = '0;
    g_word = '0;
    if (g_idx >= 0) begin
      exp_ready[g_idx] = 1'b1;
      g_word = words[g_idx];
    end
    act_ready = bus.req_ready;
    ack_s = bus.fifo_wr_ack;
    ovf_s = bus.fifo_overflow;
    @(posedge clk); #1;
    if (m_wr_d1 && !ack_s && m_nack < NACK_MAX) m_nack++;
    if (m_wr_d1 && ovf_s) m_ovf = 1'b1;
    m_wr_d1 = m_wr;
    m_wr = (g_idx >= 0);
    if (g_idx >= 0) begin
      m_ptr = (g_idx + 1) % int'(N);
      m_data = g_word;
      words[g_idx] = DW'($urandom);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < int'(N); i++) words[i] = DW'($urandom);
    fifo_rd = 1'b0; drain = 1'b1;
    force_en = 1'b0; force_ack = 1'b0; force_ovf = 1'b0;
    bus.req_valid = 4'b1111;
    #12;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ready=%b wr_en=%b exp 0000/0", bus.req_ready, bus.fifo_wr_en);
    end
    checks++;
    if (bus.fifo_data_in !== 16'h0 || bus.nack_cnt !== 8'h0 || bus.ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs data=%h nack=%0d ovf=%b exp 0", bus.fifo_data_in, bus.nack_cnt, bus.ovf_err);
    end
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    checks++;
    if (act_ready !== 4'b0100 || bus.fifo_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_write ready=%b wr_en=%b exp 0100/1", act_ready, bus.fifo_wr_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0000 || bus.fifo_data_in !== 16'h0) begin
      failures++;
      $display("FAIL async_reset wr_en=%b ready=%b data=%h exp 0", bus.fifo_wr_en, bus.req_ready, bus.fifo_data_in);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    bus.req_valid = 4'b1111;
    tick();
    checks++;
    if (act_ready !== 4'b0001 || bus.fifo_data_in !== m_data) begin
      failures++;
      $display("FAIL first_grant ready=%b data=%h exp 0001/%h", act_ready, bus.fifo_data_in, m_data);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] e;
    apply_reset();
    drain = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = '0;
      e[seq[i]] = 1'b1;
      checks++;
      if (act_ready !== e) begin
        failures++;
        $display("FAIL rr_grant step%0d got %b exp %b", i, act_ready, e);
      end
      checks++;
      if (bus.fifo_wr_en !== 1'b1 || bus.fifo_data_in !== m_data) begin
        failures++;
        $display("FAIL rr_data step%0d wr_en=%b data=%h exp 1/%h", i, bus.fifo_wr_en, bus.fifo_data_in, m_data);
      end
    end
  endtask

  task automatic test_throttle();
    int writes = 0;
    bus.req_valid = '0;
    drain = 1'b1;
    repeat (3) tick();
    drain = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (act_ready != '0) writes++;
      checks++;
      if (act_ready !== exp_ready) begin
        failures++;
        $display("FAIL throttle_grant cyc%0d got %b exp %b", i, act_ready, exp_ready);
      end
    end
    checks++;
    if (writes != DEPTH) begin
      failures++;
      $display("FAIL throttle_writes got %0d exp %0d", writes, DEPTH);
    end
    checks++;
    if (dut.state_q !== S_STALL || bus.nack_cnt !== 8'h0 || bus.ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL throttle_status state=%0d nack=%0d ovf=%b exp STALL/0/0", dut.state_q, bus.nack_cnt, bus.ovf_err);
    end
  endtask

  task automatic test_resume();
    int grants = 0;
    logic [N-1:0] first = '0;
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (act_ready != '0) begin
        grants++;
        if (grants == 1) first = act_ready;
      end
    end
    checks++;
    if (grants != 1 || first !== 4'b0010) begin
      failures++;
      $display("FAIL resume_grant count=%0d first=%b exp 1/0010", grants, first);
    end
    checks++;
    if (dut.state_q !== S_STALL) begin
      failures++;
      $display("FAIL resume_state got %0d exp %0d", dut.state_q, S_STALL);
    end
  endtask

  task automatic test_fault_inject();
    apply_reset();
    drain = 1'b1;
    force_en = 1'b1; force_ack = 1'b0; force_ovf = 1'b1;
    repeat (3) tick();
    force_en = 1'b0;
    checks++;
    if (bus.ovf_err !== 1'b0 || bus.nack_cnt !== 8'h0) begin
      failures++;
      $display("FAIL idle_overflow ovf=%b nack=%0d exp 0/0", bus.ovf_err, bus.nack_cnt);
    end
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    tick();
    force_en = 1'b1; force_ack = 1'b0; force_ovf = 1'b1;
    tick();
    force_en = 1'b0;
    checks++;
    if (bus.ovf_err !== 1'b1 || bus.nack_cnt !== 8'd1) begin
      failures++;
      $display("FAIL fault_hit ovf=%b nack=%0d exp 1/1", bus.ovf_err, bus.nack_cnt);
    end
    repeat (4) tick();
    checks++;
    if (bus.ovf_err !== m_ovf || bus.nack_cnt !== CW'(m_nack) || m_ovf !== 1'b1) begin
      failures++;
      $display("FAIL fault_sticky ovf=%b nack=%0d exp %b/%0d", bus.ovf_err, bus.nack_cnt, m_ovf, m_nack);
    end
  endtask

  task automatic test_sparse();
    apply_reset();
    drain = 1'b1;
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b1010;
    tick();
    checks++;
    if (act_ready !== 4'b1000) begin
      failures++;
      $display("FAIL sparse_first got %b exp 1000", act_ready);
    end
    tick();
    checks++;
    if (act_ready !== 4'b0010) begin
      failures++;
      $display("FAIL sparse_second got %b exp 0010", act_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_saturation();
    apply_reset();
    drain = 1'b1;
    force_en = 1'b1; force_ack = 1'b0; force_ovf = 1'b0;
    bus.req_valid = 4'b1111;
    repeat (300) tick();
    bus.req_valid = '0;
    repeat (2) tick();
    force_en = 1'b0;
    checks++;
    if (bus.nack_cnt !== 8'hFF || m_nack != NACK_MAX) begin
      failures++;
      $display("FAIL nack_saturate got %0d exp 255 (model %0d)", bus.nack_cnt, m_nack);
    end
    checks++;
    if (bus.ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL sat_ovf got %b exp 0", bus.ovf_err);
    end
  endtask

  task automatic test_random();
    apply_reset();
    drain = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = N'($urandom);
      fifo_rd = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (act_ready !== exp_ready || bus.fifo_wr_en !== m_wr) begin
        failures++;
        $display("FAIL rand_grant cyc%0d ready=%b wr_en=%b exp %b/%b", i, act_ready, bus.fifo_wr_en, exp_ready, m_wr);
      end
      if (m_wr) begin
        checks++;
        if (bus.fifo_data_in !== m_data) begin
          failures++;
          $display("FAIL rand_data cyc%0d got %h exp %h", i, bus.fifo_data_in, m_data);
        end
      end
      checks++;
      if (bus.nack_cnt !== CW'(m_nack) || bus.ovf_err !== m_ovf) begin
        failures++;
        $display("FAIL rand_status cyc%0d nack=%0d ovf=%b exp %0d/%b", i, bus.nack_cnt, bus.ovf_err, m_nack, m_ovf);
      end
    end
    bus.req_valid = '0;
    fifo_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_throttle();
    test_resume();
    test_fault_inject();
    test_sparse();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
